// File: rtl/mem_block_responder.sv
// Single-outstanding main-memory responder for the cache block-refill port.
// Accepts one block read/write, waits LATENCY cycles, then pulses mem_resp_valid.
module mem_block_responder #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 256,
  parameter int LATENCY = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req_valid,
  input  logic              mem_req_rw,
  input  logic [ADDR_W-1:0] mem_req_addr,
  input  logic [DATA_W-1:0] mem_req_wdata,
  output logic              mem_resp_valid,
  output logic [DATA_W-1:0] mem_resp_rdata,
  output logic              busy,
  output logic              proto_err,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state;
  logic [7:0]        delay_cnt;
  logic              lat_rw;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  // Blocks never written read back as their address replicated in every 16-bit
  // lane, so only a per-block written flag needs a power-up value.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written = '0;

  logic              fire;
  logic              req_differs;
  logic [DATA_W-1:0] init_block;
  logic [DATA_W-1:0] stored_block;

  assign fire         = (state == WAIT) && (delay_cnt == 8'd0);
  assign req_differs  = (mem_req_rw != lat_rw) || (mem_req_addr != lat_addr) ||
                        (mem_req_wdata != lat_wdata);
  assign init_block   = {(DATA_W/16){16'(lat_addr)}};
  assign stored_block = written[lat_addr] ? mem[lat_addr] : init_block;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst && fire && lat_rw) begin
      mem[lat_addr]     <= lat_wdata;
      written[lat_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      delay_cnt      <= 8'd0;
      lat_rw         <= 1'b0;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      mem_resp_valid <= 1'b0;
      mem_resp_rdata <= '0;
      proto_err      <= 1'b0;
      rd_count       <= 32'd0;
      wr_count       <= 32'd0;
    end else begin
      mem_resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req_valid) begin
            lat_rw    <= mem_req_rw;
            lat_addr  <= mem_req_addr;
            lat_wdata <= mem_req_wdata;
            delay_cnt <= 8'(LATENCY);
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (mem_req_valid && req_differs) begin
            proto_err <= 1'b1;
          end
          if (delay_cnt != 8'd0) begin
            delay_cnt <= delay_cnt - 8'd1;
          end else begin
            state          <= RESP;
            mem_resp_valid <= 1'b1;
            if (lat_rw) begin
              wr_count <= wr_count + 32'd1;
            end else begin
              rd_count       <= rd_count + 32'd1;
              mem_resp_rdata <= stored_block;
            end
          end
        end
        // A request still held during the response cycle must not restart.
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_block_responder.sv
// Bench for mem_block_responder: a LATENCY=50 instance for the slow-path scenarios
// and a LATENCY=0 instance for back-to-back and table-driven traffic.
module tb_mem_block_responder;

  localparam int LAT0 = 50;
  localparam int LAT1 = 0;

  logic         clk;
  logic         rst        [2];
  logic         req_valid  [2];
  logic         req_rw     [2];
  logic [14:0]  req_addr   [2];
  logic [255:0] req_wdata  [2];
  logic         resp_valid [2];
  logic [255:0] resp_rdata [2];
  logic         busy       [2];
  logic         proto_err  [2];
  logic [31:0]  rd_count   [2];
  logic [31:0]  wr_count   [2];

  int checks = 0;
  int errors = 0;
  int busy_drop = 0;
  int exp_rd [2];
  int exp_wr [2];
  logic [255:0] last_rd [2];
  logic [255:0] sbq0 [$];
  logic [255:0] sbq1 [$];

  typedef struct {
    logic         rw;
    logic [14:0]  addr;
    logic [255:0] wdata;
    logic [255:0] exp;
  } vec_t;

  vec_t vecs [9];

  mem_block_responder #(.ADDR_W(15), .DATA_W(256), .LATENCY(LAT0)) dut_slow (
    .clk(clk), .rst(rst[0]), .mem_req_valid(req_valid[0]), .mem_req_rw(req_rw[0]),
    .mem_req_addr(req_addr[0]), .mem_req_wdata(req_wdata[0]),
    .mem_resp_valid(resp_valid[0]), .mem_resp_rdata(resp_rdata[0]), .busy(busy[0]),
    .proto_err(proto_err[0]), .rd_count(rd_count[0]), .wr_count(wr_count[0])
  );

  mem_block_responder #(.ADDR_W(15), .DATA_W(256), .LATENCY(LAT1)) dut_fast (
    .clk(clk), .rst(rst[1]), .mem_req_valid(req_valid[1]), .mem_req_rw(req_rw[1]),
    .mem_req_addr(req_addr[1]), .mem_req_wdata(req_wdata[1]),
    .mem_resp_valid(resp_valid[1]), .mem_resp_rdata(resp_rdata[1]), .busy(busy[1]),
    .proto_err(proto_err[1]), .rd_count(rd_count[1]), .wr_count(wr_count[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] pat(input logic [15:0] a);
    return {16{a}};
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resp_valid[0] === 1'b1) begin
      if (sbq0.size() == 0) checkOutput("unexpected_pulse_slow", 1, 0);
      else checkOutput("resp_rdata_slow", resp_rdata[0], sbq0.pop_front());
    end
    if (resp_valid[1] === 1'b1) begin
      if (sbq1.size() == 0) checkOutput("unexpected_pulse_fast", 1, 0);
      else checkOutput("resp_rdata_fast", resp_rdata[1], sbq1.pop_front());
    end
  end

  task automatic applyStimulus(input int d, input logic rw, input logic [14:0] addr,
                               input logic [255:0] wdata, input logic [255:0] exp,
                               input bit hold, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy[d] && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    req_valid[d] = 1'b1;
    req_rw[d]    = rw;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    if (d == 0) sbq0.push_back(exp);
    else sbq1.push_back(exp);
    @(posedge clk);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      if (!busy[d]) busy_drop++;
    end while (!resp_valid[d] && lat < 300);
    if (resp_valid[d]) begin
      if (rw) exp_wr[d]++;
      else begin
        exp_rd[d]++;
        last_rd[d] = exp;
      end
    end
    if (hold) begin
      @(posedge clk);
      #1;
    end
    req_valid[d] = 1'b0;
  endtask

  initial begin
    int lat;
    int p1;
    int p2;
    int n;

    vecs[0] = '{1'b0, 15'h0005, 256'h0, pat(16'h0005)};
    vecs[1] = '{1'b1, 15'h0005, {8{32'hA5A5_0F0F}}, pat(16'h0005)};
    vecs[2] = '{1'b0, 15'h0005, 256'h0, {8{32'hA5A5_0F0F}}};
    vecs[3] = '{1'b0, 15'h7FFF, 256'h0, pat(16'h7FFF)};
    vecs[4] = '{1'b1, 15'h7FFF, {4{64'h0123_4567_89AB_CDEF}}, pat(16'h7FFF)};
    vecs[5] = '{1'b1, 15'h0000, {32{8'h3C}}, pat(16'h7FFF)};
    vecs[6] = '{1'b0, 15'h7FFF, 256'h0, {4{64'h0123_4567_89AB_CDEF}}};
    vecs[7] = '{1'b0, 15'h0000, 256'h0, {32{8'h3C}}};
    vecs[8] = '{1'b0, 15'h1234, 256'h0, pat(16'h1234)};

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_rw[d] = 1'b0;
      req_addr[d] = '0; req_wdata[d] = '0;
      exp_rd[d] = 0; exp_wr[d] = 0; last_rd[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput("reset_resp_valid", resp_valid[d], 0);
      checkOutput("reset_rdata", resp_rdata[d], 0);
      checkOutput("reset_busy", busy[d], 0);
      checkOutput("reset_proto_err", proto_err[d], 0);
      checkOutput("reset_rd_count", rd_count[d], 0);
      checkOutput("reset_wr_count", wr_count[d], 0);
    end

    // Slow instance: latency, write-then-read, and held-valid cooldown
    applyStimulus(0, 1'b0, 15'h0100, 256'h0, pat(16'h0100), 1'b0, lat);
    checkOutput("t1_latency", lat, LAT0 + 1);
    checkOutput("t1_rd_count", rd_count[0], exp_rd[0]);
    applyStimulus(0, 1'b1, 15'h4000, {8{32'hDEADBEEF}}, last_rd[0], 1'b0, lat);
    checkOutput("t2_write_latency", lat, LAT0 + 1);
    applyStimulus(0, 1'b0, 15'h4000, 256'h0, {8{32'hDEADBEEF}}, 1'b0, lat);
    checkOutput("t2_wr_count", wr_count[0], 1);
    checkOutput("t2_rd_count", rd_count[0], 2);
    applyStimulus(0, 1'b0, 15'h0003, 256'h0, pat(16'h0003), 1'b1, lat);
    repeat (LAT0 + 10) @(negedge clk);
    checkOutput("t3_idle_after_hold", busy[0], 0);
    checkOutput("t3_rd_count", rd_count[0], exp_rd[0]);

    // Request fields change mid-wait; original request must still be served
    @(negedge clk);
    req_valid[0] = 1'b1; req_rw[0] = 1'b0; req_addr[0] = 15'h0010; req_wdata[0] = '0;
    sbq0.push_back(pat(16'h0010));
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("t4_proto_err_before", proto_err[0], 0);
    req_addr[0] = 15'h0011;
    n = 0;
    while (!resp_valid[0] && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("t4_pulse_seen", resp_valid[0], 1);
    checkOutput("t4_proto_err_set", proto_err[0], 1);
    if (resp_valid[0]) begin
      exp_rd[0]++;
      last_rd[0] = pat(16'h0010);
    end
    req_valid[0] = 1'b0;
    req_addr[0] = 15'h0010;
    repeat (5) @(negedge clk);
    checkOutput("t4_proto_err_sticky", proto_err[0], 1);

    // Reset 20 cycles into a write: no pulse, no commit
    @(negedge clk);
    req_valid[0] = 1'b1; req_rw[0] = 1'b1; req_addr[0] = 15'h0200;
    req_wdata[0] = {8{32'hCAFE_F00D}};
    @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    rst[0] = 1'b1;
    req_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    exp_rd[0] = 0; exp_wr[0] = 0; last_rd[0] = '0;
    @(negedge clk);
    checkOutput("t5_busy", busy[0], 0);
    checkOutput("t5_rd_count", rd_count[0], 0);
    checkOutput("t5_wr_count", wr_count[0], 0);
    checkOutput("t5_proto_err_cleared", proto_err[0], 0);
    repeat (LAT0 + 10) @(negedge clk);
    applyStimulus(0, 1'b0, 15'h0200, 256'h0, pat(16'h0200), 1'b0, lat);
    checkOutput("t5_wr_count_after", wr_count[0], 0);

    // Fast instance: held valid with address switched on the first pulse
    p1 = -1;
    p2 = -1;
    @(negedge clk);
    req_valid[1] = 1'b1; req_rw[1] = 1'b0; req_addr[1] = 15'h0001;
    sbq1.push_back(pat(16'h0001));
    sbq1.push_back(pat(16'h0002));
    for (int k = 1; k <= 20 && p2 < 0; k++) begin
      @(posedge clk);
      #1;
      if (resp_valid[1]) begin
        if (p1 < 0) begin
          p1 = k;
          req_addr[1] = 15'h0002;
        end else p2 = k;
      end
    end
    req_valid[1] = 1'b0;
    checkOutput("t6_first_pulse", p1, 2);
    checkOutput("t6_pulse_spacing", p2 - p1, 3);
    if (p2 > 0) begin
      exp_rd[1] += 2;
      last_rd[1] = pat(16'h0002);
    end
    @(negedge clk);
    checkOutput("t6_proto_err", proto_err[1], 0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].exp, 1'b0, lat);
      checkOutput("table_latency", lat, LAT1 + 1);
    end
    repeat (4) @(negedge clk);
    checkOutput("table_rd_count", rd_count[1], exp_rd[1]);
    checkOutput("table_wr_count", wr_count[1], exp_wr[1]);

    checkOutput("busy_throughout", busy_drop, 0);
    checkOutput("sb_slow_drained", sbq0.size(), 0);
    checkOutput("sb_fast_drained", sbq1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
